// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table gate evaluator.
package truth_table_pkg;

  localparam int TT_MAX_IN = 6;
  localparam int TT_MAX_W  = 1 << TT_MAX_IN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } load_state_e;

  // The table must be left-justified in the 64-bit word, so that the
  // MSB-first index 2^N-1-idx becomes 63-idx whatever N is.
  function automatic logic tt_lookup(input logic [TT_MAX_W-1:0] tt,
                                     input logic [TT_MAX_IN-1:0] idx);
    return tt[TT_MAX_IN'(TT_MAX_W - 1) - idx];
  endfunction

endpackage

// File: rtl/truth_table_eval_loader.sv
// Serial truth-table loader: shifts bits MSB first into a shadow table and
// raises commit for one cycle once the whole table has arrived.
module tt_serial_loader
  import truth_table_pkg::*;
#(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  output logic          commit,
  output logic [TW-1:0] new_tt
);

  localparam int CW = $clog2(TW) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(TW - 1);

  load_state_e   state_q, state_d;
  logic [TW-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          shadow_d = {shadow_q[TW-2:0], cfg_bit};
          cnt_d    = CW'(1);
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (cfg_valid) begin
          shadow_d = {shadow_q[TW-2:0], cfg_bit};
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = COMMIT;
        end
      end
      COMMIT: begin
        // A bit arriving while the previous table commits opens the next load.
        cnt_d   = '0;
        state_d = IDLE;
        if (cfg_valid) begin
          shadow_d = {shadow_q[TW-2:0], cfg_bit};
          cnt_d    = CW'(1);
          state_d  = SHIFT;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign commit = (state_q == COMMIT);
  assign new_tt = shadow_q;

endmodule

// File: rtl/truth_table_eval.sv
// Clocked N_IN-input truth-table gate with valid/ready eval path and serial
// table reload. Optional persistence filter on out: TRUTH_TABLE_PERSIST_EN.
module truth_table_eval
  import truth_table_pkg::*;
#(
  parameter int                    N_IN    = 3,
  parameter logic [(1<<N_IN)-1:0]  TT_INIT = 8'hAF,
  parameter int                    PERSIST = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN-1:0]        in_vec,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   cfg_valid,
  input  logic                   cfg_bit,
  output logic                   cfg_ready,
  output logic [(1<<N_IN)-1:0]   tt_cur
);

  localparam int TW = 1 << N_IN;

  if (N_IN < 1 || N_IN > TT_MAX_IN) begin : g_bad_n_in
    $error("truth_table_eval: N_IN out of range");
  end
  if (PERSIST < 1 || PERSIST > 15) begin : g_bad_persist
    $error("truth_table_eval: PERSIST out of range");
  end

  logic          commit;
  logic [TW-1:0] new_tt;
  logic [TW-1:0] tt_cur_q, tt_cur_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          accept;
  logic          raw;

  tt_serial_loader #(.TW(TW)) u_loader (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .commit    (commit),
    .new_tt    (new_tt)
  );

  assign in_ready  = !rst && (!out_valid_q || out_ready);
  assign cfg_ready = !rst;
  assign accept    = in_valid && in_ready;
  assign raw       = tt_lookup(TT_MAX_W'(tt_cur_q) << (TT_MAX_W - TW), TT_MAX_IN'(in_vec));

  // A sample accepted in the commit cycle still sees the old table.
  always_comb begin
    tt_cur_d    = commit ? new_tt : tt_cur_q;
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

`ifdef TRUTH_TABLE_PERSIST_EN
  logic [3:0] run_q, run_d;

  always_comb begin
    out_d = out_q;
    run_d = run_q;
    if (accept) begin
      if (raw == out_q) begin
        run_d = '0;
      end else if (run_q + 4'd1 >= 4'(PERSIST)) begin
        out_d = raw;
        run_d = '0;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
    if (commit) run_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= '0;
    else     run_q <= run_d;
  end
`else
  always_comb begin
    out_d = accept ? raw : out_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt_cur_q    <= TT_INIT;
      out_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      tt_cur_q    <= tt_cur_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign tt_cur    = tt_cur_q;

endmodule

// File: tb/tb_truth_table_eval.sv
// Bench for truth_table_eval: directed and randomized traffic against a
// behavioural model of table lookup, handshake and serial reload.
module tb_truth_table_eval;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_vec;
  logic       in_valid, in_ready, out, out_valid, out_ready;
  logic       cfg_valid, cfg_bit, cfg_ready;
  logic [7:0] tt_cur;

  logic [3:0]  in_vec4;
  logic        in_valid4, in_ready4, out4, out_valid4, out_ready4;
  logic        cfg_valid4, cfg_bit4, cfg_ready4;
  logic [15:0] tt_cur4;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state
  bit [7:0] m_tt, m_sh, m_snap;
  int       m_cnt, m_run;
  bit       m_pend, m_ov, m_out, m_acc;

  always #5 clk = ~clk;

  truth_table_eval #(.N_IN(3), .TT_INIT(8'hAF), .PERSIST(2)) dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .tt_cur(tt_cur)
  );

  truth_table_eval #(.N_IN(4), .TT_INIT(16'h8000), .PERSIST(2)) dut4 (
    .clk(clk), .rst(rst), .in_vec(in_vec4), .in_valid(in_valid4),
    .in_ready(in_ready4), .out(out4), .out_valid(out_valid4),
    .out_ready(out_ready4), .cfg_valid(cfg_valid4), .cfg_bit(cfg_bit4),
    .cfg_ready(cfg_ready4), .tt_cur(tt_cur4)
  );

  task automatic model_reset();
    m_tt = 8'hAF; m_sh = '0; m_snap = '0; m_cnt = 0; m_run = 0;
    m_pend = 0; m_ov = 0; m_out = 0; m_acc = 0;
  endtask

  // Drive one cycle on the N_IN=3 DUT and advance the model across the edge.
  task automatic step(input logic [2:0] v, input logic iv, input logic ordy,
                      input logic cv, input logic cb);
    bit raw;
    @(negedge clk);
    in_vec = v; in_valid = iv; out_ready = ordy; cfg_valid = cv; cfg_bit = cb;
    m_acc = iv && (!m_ov || ordy);
    @(posedge clk);
    raw = m_tt[7 - int'(v)];
    if (m_acc) begin
      m_ov = 1;
`ifdef TRUTH_TABLE_PERSIST_EN
      if (raw == m_out) m_run = 0;
      else begin
        m_run++;
        if (m_run >= 2) begin m_out = raw; m_run = 0; end
      end
`else
      m_out = raw;
`endif
    end else if (ordy) begin
      m_ov = 0;
    end
    if (m_pend) begin m_tt = m_snap; m_pend = 0; m_run = 0; end
    if (cv) begin
      m_sh = {m_sh[6:0], cb};
      m_cnt++;
      if (m_cnt == 8) begin m_pend = 1; m_snap = m_sh; m_cnt = 0; end
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; out_ready = 1; cfg_valid = 0; cfg_bit = 0;
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (out !== 1'b0) $display("FAIL rst_out got %b want 0", out); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else n_pass++;
    n_total++; if (cfg_ready !== 1'b0) $display("FAIL rst_cfg_ready got %b want 0", cfg_ready); else n_pass++;
    n_total++; if (tt_cur !== 8'hAF) $display("FAIL rst_tt_cur got %h want af", tt_cur); else n_pass++;
    n_total++; if (tt_cur4 !== 16'h8000) $display("FAIL rst_tt_cur4 got %h want 8000", tt_cur4); else n_pass++;
    @(negedge clk);
    rst = 0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (cfg_ready !== 1'b1) $display("FAIL post_rst_cfg_ready got %b want 1", cfg_ready); else n_pass++;
  endtask

  task automatic test_truth_table();
    bit [7:0] want;
    want = 8'b1010_1111;  // out for in_vec 0..7, in_vec 0 first
    for (int i = 0; i < 8; i++) begin
      step(3'(i), 1, 1, 0, 0);
      n_total++;
      if (out_valid !== 1'b1 || out !== want[7-i])
        $display("FAIL tt_af idx=%0d got valid=%b out=%b want valid=1 out=%b", i, out_valid, out, want[7-i]);
      else n_pass++;
    end
    step(0, 0, 1, 0, 0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL tt_drain got valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    step(3, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out !== 1'b0 || in_ready !== 1'b0)
        $display("FAIL hold cyc=%0d got valid=%b out=%b in_ready=%b want 1 0 0", i, out_valid, out, in_ready);
      else n_pass++;
      step(5, 1, 0, 0, 0);
    end
    @(negedge clk);
    out_ready = 1; in_valid = 0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL hold_release in_ready got %b want 1", in_ready); else n_pass++;
    step(0, 0, 1, 0, 0);
    n_total++; if (out_valid !== 1'b0) $display("FAIL hold_drain got valid=%b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_load_xor();
    bit [7:0] pat;
    pat = 8'h96;
    for (int k = 0; k < 8; k++) begin
      step(7, 1, 1, 1, pat[7-k]);
      n_total++;
      if (out !== 1'b1) $display("FAIL load_stream k=%0d got %b want 1", k, out); else n_pass++;
    end
    step(7, 1, 1, 0, 0);  // commit cycle: sample still on 0xAF
    n_total++; if (out !== 1'b1) $display("FAIL commit_cycle out got %b want 1", out); else n_pass++;
    n_total++; if (tt_cur !== 8'h96) $display("FAIL commit_tt got %h want 96", tt_cur); else n_pass++;
    step(7, 1, 1, 0, 0);
    n_total++; if (out !== m_out) $display("FAIL new_tt idx7 got %b want %b", out, m_out); else n_pass++;
    step(3, 1, 1, 0, 0);
    n_total++; if (out !== m_out) $display("FAIL new_tt idx3 got %b want %b", out, m_out); else n_pass++;
  endtask

  task automatic test_reset_midload();
    bit [7:0] pat;
    for (int k = 0; k < 5; k++) step(0, 0, 1, 1, 1'b1);
    @(negedge clk);
    rst = 1; cfg_valid = 0; in_valid = 0;
    #1;
    model_reset();
    n_total++; if (tt_cur !== 8'hAF) $display("FAIL midload_tt got %h want af", tt_cur); else n_pass++;
    n_total++; if (cfg_ready !== 1'b0) $display("FAIL midload_cfg_ready got %b want 0", cfg_ready); else n_pass++;
    @(negedge clk);
    rst = 0;
    pat = 8'h01;
    for (int k = 0; k < 8; k++) step(0, 0, 1, 1, pat[7-k]);
    step(0, 0, 1, 0, 0);
    n_total++; if (tt_cur !== 8'h01) $display("FAIL reload_tt got %h want 01", tt_cur); else n_pass++;
    step(7, 1, 1, 0, 0);
    n_total++; if (out !== m_out) $display("FAIL reload_idx7 got %b want %b", out, m_out); else n_pass++;
    step(0, 1, 1, 0, 0);
    n_total++; if (out !== m_out) $display("FAIL reload_idx0 got %b want %b", out, m_out); else n_pass++;
  endtask

  task automatic test_random();
    logic [2:0] v;
    logic iv, ordy, cv, cb;
    for (int c = 0; c < 300; c++) begin
      v = 3'($urandom_range(0, 7));
      iv = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      cv = 1'($urandom_range(0, 1));
      cb = 1'($urandom_range(0, 1));
      step(v, iv, ordy, cv, cb);
      n_total++;
      if (out_valid !== m_ov || out !== m_out || tt_cur !== m_tt ||
          in_ready !== (!m_ov || ordy))
        $display("FAIL rand c=%0d got v=%b o=%b tt=%h rdy=%b want v=%b o=%b tt=%h rdy=%b",
                 c, out_valid, out, tt_cur, in_ready, m_ov, m_out, m_tt, (!m_ov || ordy));
      else n_pass++;
    end
  endtask

  task automatic test_n4();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_vec4 = 4'(i); in_valid4 = 1; out_ready4 = 1;
      @(posedge clk);
      #1;
      n_total++;
      if (out_valid4 !== 1'b1 || out4 !== (i == 0))
        $display("FAIL n4 idx=%0d got valid=%b out=%b want valid=1 out=%b", i, out_valid4, out4, (i == 0));
      else n_pass++;
    end
    @(negedge clk);
    in_valid4 = 0;
  endtask

`ifdef TRUTH_TABLE_PERSIST_EN
  task automatic test_persist();
    logic [2:0] seq [5] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd1};
    bit   [4:0] want = 5'b11110;
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    n_total++; if (out !== 1'b1) $display("FAIL persist_prime got %b want 1", out); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1, 1, 0, 0);
      n_total++;
      if (out !== want[4-i] || out_valid !== 1'b1)
        $display("FAIL persist i=%0d got out=%b valid=%b want out=%b valid=1", i, out, out_valid, want[4-i]);
      else n_pass++;
    end
  endtask
`endif

  initial begin
    rst = 1;
    in_vec = 0; in_valid = 0; out_ready = 1; cfg_valid = 0; cfg_bit = 0;
    in_vec4 = 0; in_valid4 = 0; out_ready4 = 1; cfg_valid4 = 0; cfg_bit4 = 0;
    model_reset();
    test_reset();
    test_truth_table();
    test_backpressure();
    test_load_xor();
    apply_reset();
    test_reset_midload();
    apply_reset();
    test_n4();
`ifdef TRUTH_TABLE_PERSIST_EN
    apply_reset();
    test_persist();
`endif
    apply_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
